// File: rtl/sram64_axi_bridge.sv
// Bridges SRAM-style byte-enable requests onto a 64-bit AXI4-Lite master port.
// One transaction outstanding at a time, with a one-cycle completion pulse per request.
module sram64_axi_bridge #(
    parameter int unsigned ADDR_WIDTH = 64,
    parameter bit          ALIGN_ADDR = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [7:0]            req_wea,
    input  logic [63:0]           req_dina,
    input  logic                  req_ren,

    output logic                  resp_valid,
    output logic [63:0]           resp_rdata,
    output logic                  resp_err,

    output logic                  m_awvalid,
    input  logic                  m_awready,
    output logic [ADDR_WIDTH-1:0] m_awaddr,

    output logic                  m_wvalid,
    input  logic                  m_wready,
    output logic [63:0]           m_wdata,
    output logic [7:0]            m_wstrb,

    input  logic                  m_bvalid,
    output logic                  m_bready,
    input  logic [1:0]            m_bresp,

    output logic                  m_arvalid,
    input  logic                  m_arready,
    output logic [ADDR_WIDTH-1:0] m_araddr,

    input  logic                  m_rvalid,
    output logic                  m_rready,
    input  logic [63:0]           m_rdata,
    input  logic [1:0]            m_rresp
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ALIGN_ADDR ? ~ADDR_WIDTH'(7) : '1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_WB,
        ST_RA,
        ST_RD
    } state_t;

    state_t state;
    logic   aw_done;
    logic   w_done;

    logic                  aw_hs;
    logic                  w_hs;
    logic                  aw_done_n;
    logic                  w_done_n;
    logic                  req_is_wr;
    logic [ADDR_WIDTH-1:0] bus_addr;

    // Handshake and done tracking for the independent AW/W channels
    assign aw_hs     = m_awvalid & m_awready;
    assign w_hs      = m_wvalid & m_wready;
    assign aw_done_n = aw_done | aw_hs;
    assign w_done_n  = w_done | w_hs;
    assign req_is_wr = (req_wea != 8'h00);
    assign bus_addr  = req_addr & ADDR_MASK;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= 64'h0;
            resp_err   <= 1'b0;
            m_awvalid  <= 1'b0;
            m_awaddr   <= '0;
            m_wvalid   <= 1'b0;
            m_wdata    <= 64'h0;
            m_wstrb    <= 8'h00;
            m_bready   <= 1'b0;
            m_arvalid  <= 1'b0;
            m_araddr   <= '0;
            m_rready   <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        if (req_is_wr) begin
                            state     <= ST_WR;
                            req_ready <= 1'b0;
                            aw_done   <= 1'b0;
                            w_done    <= 1'b0;
                            m_awvalid <= 1'b1;
                            m_awaddr  <= bus_addr;
                            m_wvalid  <= 1'b1;
                            m_wdata   <= req_dina;
                            m_wstrb   <= req_wea;
                        end else if (req_ren) begin
                            state     <= ST_RA;
                            req_ready <= 1'b0;
                            m_arvalid <= 1'b1;
                            m_araddr  <= bus_addr;
                        end else begin
                            // Empty request: acknowledge immediately without touching the bus
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b0;
                        end
                    end
                end

                ST_WR: begin
                    if (aw_hs) begin
                        m_awvalid <= 1'b0;
                    end
                    if (w_hs) begin
                        m_wvalid <= 1'b0;
                    end
                    aw_done <= aw_done_n;
                    w_done  <= w_done_n;
                    if (aw_done_n && w_done_n) begin
                        state    <= ST_WB;
                        m_bready <= 1'b1;
                    end
                end

                ST_WB: begin
                    if (m_bvalid) begin
                        state      <= ST_IDLE;
                        m_bready   <= 1'b0;
                        req_ready  <= 1'b1;
                        resp_valid <= 1'b1;
                        resp_err   <= (m_bresp != 2'b00);
                    end
                end

                ST_RA: begin
                    if (m_arready) begin
                        state     <= ST_RD;
                        m_arvalid <= 1'b0;
                        m_rready  <= 1'b1;
                    end
                end

                ST_RD: begin
                    if (m_rvalid) begin
                        // Data is captured even on an error response
                        state      <= ST_IDLE;
                        m_rready   <= 1'b0;
                        req_ready  <= 1'b1;
                        resp_valid <= 1'b1;
                        resp_rdata <= m_rdata;
                        resp_err   <= (m_rresp != 2'b00);
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram64_axi_bridge.sv
// Self-checking bench for sram64_axi_bridge: transaction-level model plus directed
// scenarios with hand-computed expectations, then randomized requests and slave timing.
module tb_sram64_axi_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_addr;
    logic [7:0]  req_wea;
    logic [63:0] req_dina;
    logic        req_ren;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        resp_err;
    logic        m_awvalid;
    logic        m_awready;
    logic [63:0] m_awaddr;
    logic        m_wvalid;
    logic        m_wready;
    logic [63:0] m_wdata;
    logic [7:0]  m_wstrb;
    logic        m_bvalid;
    logic        m_bready;
    logic [1:0]  m_bresp;
    logic        m_arvalid;
    logic        m_arready;
    logic [63:0] m_araddr;
    logic        m_rvalid;
    logic        m_rready;
    logic [63:0] m_rdata;
    logic [1:0]  m_rresp;

    always #5 clk = ~clk;

    sram64_axi_bridge #(.ADDR_WIDTH(64), .ALIGN_ADDR(1'b1)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_wea(req_wea), .req_dina(req_dina), .req_ren(req_ren),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr),
        .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int n_resp = 0;

    // Transaction-level expectation: which channel obligations are open and what must be seen
    bit          e_busy, e_aw, e_w, e_b, e_ar, e_r, e_resp, e_err;
    logic [63:0] e_rdata, e_awaddr, e_wdata, e_araddr;
    logic [7:0]  e_wstrb;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the expectation across one rising edge using the inputs now applied
    task automatic predict();
        bit aw_left, w_left;
        e_resp = 1'b0;
        if (rst) begin
            {e_busy, e_aw, e_w, e_b, e_ar, e_r, e_err} = '0;
            e_rdata = 64'h0;
        end else if (!e_busy) begin
            if (req_valid) begin
                if (req_wea != 8'h00) begin
                    e_busy = 1'b1; e_aw = 1'b1; e_w = 1'b1;
                    e_awaddr = req_addr & ~64'h7;
                    e_wdata  = req_dina;
                    e_wstrb  = req_wea;
                end else if (req_ren) begin
                    e_busy = 1'b1; e_ar = 1'b1;
                    e_araddr = req_addr & ~64'h7;
                end else begin
                    e_resp = 1'b1; e_err = 1'b0;
                end
            end
        end else if (e_aw || e_w) begin
            aw_left = e_aw && !m_awready;
            w_left  = e_w && !m_wready;
            e_aw = aw_left;
            e_w  = w_left;
            if (!aw_left && !w_left) e_b = 1'b1;
        end else if (e_b) begin
            if (m_bvalid) begin
                e_b = 1'b0; e_busy = 1'b0; e_resp = 1'b1; e_err = (m_bresp != 2'b00);
            end
        end else if (e_ar) begin
            if (m_arready) begin
                e_ar = 1'b0; e_r = 1'b1;
            end
        end else if (e_r) begin
            if (m_rvalid) begin
                e_r = 1'b0; e_busy = 1'b0; e_resp = 1'b1;
                e_err = (m_rresp != 2'b00); e_rdata = m_rdata;
            end
        end
    endtask

    task automatic compare();
        chk1("req_ready", req_ready, !e_busy);
        chk1("resp_valid", resp_valid, e_resp);
        if (e_resp) chk1("resp_err", resp_err, e_err);
        chk64("resp_rdata", resp_rdata, e_rdata);
        chk1("m_awvalid", m_awvalid, e_aw);
        chk1("m_wvalid", m_wvalid, e_w);
        chk1("m_bready", m_bready, e_b);
        chk1("m_arvalid", m_arvalid, e_ar);
        chk1("m_rready", m_rready, e_r);
        if (e_aw) chk64("m_awaddr", m_awaddr, e_awaddr);
        if (e_w) begin
            chk64("m_wdata", m_wdata, e_wdata);
            chk64("m_wstrb", 64'(m_wstrb), 64'(e_wstrb));
        end
        if (e_ar) chk64("m_araddr", m_araddr, e_araddr);
    endtask

    task automatic tick();
        predict();
        @(negedge clk);
        compare();
        if (resp_valid) n_resp++;
    endtask

    task automatic clr_in();
        req_valid = 1'b0; req_addr = 64'h0; req_wea = 8'h00; req_dina = 64'h0; req_ren = 1'b0;
        m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0; m_bresp = 2'b00;
        m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = 64'h0; m_rresp = 2'b00;
    endtask

    // One request against an always-ready slave; reports latency and channel activity
    task automatic do_txn(input logic [63:0] addr, input logic [7:0] wea, input logic [63:0] dina,
                          input logic ren, input logic [1:0] bresp, input logic [1:0] rresp,
                          input logic [63:0] rdata, output int lat, output bit saw_aw,
                          output bit saw_ar, output logic [63:0] first_awaddr,
                          output logic [7:0] first_wstrb);
        req_valid = 1'b1; req_addr = addr; req_wea = wea; req_dina = dina; req_ren = ren;
        m_awready = 1'b1; m_wready = 1'b1; m_bvalid = 1'b1; m_bresp = bresp;
        m_arready = 1'b1; m_rvalid = 1'b1; m_rresp = rresp; m_rdata = rdata;
        tick();
        req_valid = 1'b0;
        lat = 1;
        first_awaddr = m_awaddr;
        first_wstrb  = m_wstrb;
        saw_aw = m_awvalid;
        saw_ar = m_arvalid;
        while (!resp_valid && lat < 20) begin
            tick();
            lat++;
            saw_aw |= m_awvalid;
            saw_ar |= m_arvalid;
        end
        chk1("txn_timeout", 1'(lat < 20), 1'b1);
        clr_in();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int          lat, cnt;
        bit          saw_aw, saw_ar, rr_seen;
        logic [63:0] faddr;
        logic [7:0]  fstrb;

        clr_in();
        rst = 1'b1;
        @(negedge clk);
        tick();
        chk1("reset req_ready", req_ready, 1'b1);
        chk1("reset resp_err", resp_err, 1'b0);
        chk64("reset awaddr", m_awaddr, 64'h0);
        chk64("reset araddr", m_araddr, 64'h0);
        chk64("reset wdata", m_wdata, 64'h0);
        chk64("reset wstrb", 64'(m_wstrb), 64'h0);
        rst = 1'b0;
        tick();

        // Write against a fast slave
        do_txn(64'h1000_0005, 8'h20, 64'h0000_AB00_0000_0000, 1'b0, 2'b00, 2'b00, 64'h0,
               lat, saw_aw, saw_ar, faddr, fstrb);
        chk64("fast write awaddr", faddr, 64'h1000_0000);
        chk64("fast write wstrb", 64'(fstrb), 64'h20);
        chk64("fast write latency", 64'(lat), 64'd3);
        chk1("fast write err", resp_err, 1'b0);

        // Skewed write: AW accepted at once, W four cycles late
        req_valid = 1'b1; req_addr = 64'h2000_0013; req_wea = 8'h0F;
        req_dina = 64'hDEAD_BEEF_0123_4567; req_ren = 1'b0;
        tick();
        req_valid = 1'b0;
        m_awready = 1'b1;
        tick();
        m_awready = 1'b0;
        chk1("skew awvalid dropped", m_awvalid, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk1("skew wvalid held", m_wvalid, 1'b1);
            chk64("skew wdata stable", m_wdata, 64'hDEAD_BEEF_0123_4567);
            chk1("skew bready early", m_bready, 1'b0);
        end
        m_wready = 1'b1;
        tick();
        m_wready = 1'b0;
        chk1("skew bready", m_bready, 1'b1);
        m_bvalid = 1'b1;
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (resp_valid) cnt++;
            m_bvalid = 1'b0;
        end
        chk64("skew resp count", 64'(cnt), 64'd1);

        // Read with address and data stalls
        req_valid = 1'b1; req_ren = 1'b1; req_wea = 8'h00; req_addr = 64'h8;
        tick();
        req_valid = 1'b0; req_ren = 1'b0;
        rr_seen = req_ready;
        chk64("stall araddr", m_araddr, 64'h8);
        for (int i = 0; i < 2; i++) begin tick(); rr_seen |= req_ready; end
        m_arready = 1'b1;
        tick();
        rr_seen |= req_ready;
        m_arready = 1'b0;
        for (int i = 0; i < 2; i++) begin tick(); rr_seen |= req_ready; end
        m_rvalid = 1'b1; m_rdata = 64'h1122_3344_5566_7788; m_rresp = 2'b00;
        tick();
        m_rvalid = 1'b0;
        chk1("stall resp_valid", resp_valid, 1'b1);
        chk64("stall rdata", resp_rdata, 64'h1122_3344_5566_7788);
        chk1("stall err", resp_err, 1'b0);
        chk1("stall req_ready low", rr_seen, 1'b0);
        clr_in();
        tick();

        // Error responses, then an OKAY read clears the flag
        do_txn(64'h3000, 8'h01, 64'h55, 1'b0, 2'b10, 2'b00, 64'h0, lat, saw_aw, saw_ar, faddr, fstrb);
        chk1("bresp err", resp_err, 1'b1);
        chk64("bresp rdata untouched", resp_rdata, 64'h1122_3344_5566_7788);
        do_txn(64'h3008, 8'h00, 64'h0, 1'b1, 2'b00, 2'b11, 64'hA5A5_0000_FFFF_1234,
               lat, saw_aw, saw_ar, faddr, fstrb);
        chk1("rresp err", resp_err, 1'b1);
        chk64("rresp rdata captured", resp_rdata, 64'hA5A5_0000_FFFF_1234);
        do_txn(64'h3010, 8'h00, 64'h0, 1'b1, 2'b00, 2'b00, 64'h0BAD_F00D_0000_0001,
               lat, saw_aw, saw_ar, faddr, fstrb);
        chk1("okay read clears err", resp_err, 1'b0);
        chk64("fast read latency", 64'(lat), 64'd3);

        // No-op and write-over-read priority
        do_txn(64'h40, 8'h00, 64'h0, 1'b0, 2'b00, 2'b00, 64'h0, lat, saw_aw, saw_ar, faddr, fstrb);
        chk64("noop latency", 64'(lat), 64'd1);
        chk1("noop no aw", saw_aw, 1'b0);
        chk1("noop no ar", saw_ar, 1'b0);
        chk1("noop err", resp_err, 1'b0);
        do_txn(64'h48, 8'hFF, 64'h0123_4567_89AB_CDEF, 1'b1, 2'b00, 2'b00, 64'h0,
               lat, saw_aw, saw_ar, faddr, fstrb);
        chk1("priority aw", saw_aw, 1'b1);
        chk1("priority no ar", saw_ar, 1'b0);

        // Reset while waiting on R
        req_valid = 1'b1; req_ren = 1'b1; req_addr = 64'h50;
        tick();
        req_valid = 1'b0; req_ren = 1'b0;
        m_arready = 1'b1;
        tick();
        m_arready = 1'b0;
        chk1("pre-reset rready", m_rready, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk1("midrst rready", m_rready, 1'b0);
        chk1("midrst req_ready", req_ready, 1'b1);
        chk1("midrst resp_valid", resp_valid, 1'b0);
        chk64("midrst rdata", resp_rdata, 64'h0);
        tick();
        chk1("midrst no late resp", resp_valid, 1'b0);
        do_txn(64'h58, 8'h00, 64'h0, 1'b1, 2'b00, 2'b00, 64'hCAFE_BABE_1357_9BDF,
               lat, saw_aw, saw_ar, faddr, fstrb);
        chk64("post-reset rdata", resp_rdata, 64'hCAFE_BABE_1357_9BDF);
        chk64("post-reset latency", 64'(lat), 64'd3);

        // Randomized requests, slave timing and occasional resets
        n_resp = 0;
        for (int c = 0; c < 4000; c++) begin
            rst       = ($urandom_range(0, 599) == 0);
            req_valid = ($urandom_range(0, 3) != 0);
            req_addr  = {$urandom, $urandom};
            req_wea   = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
            req_dina  = {$urandom, $urandom};
            req_ren   = 1'($urandom);
            m_awready = ($urandom_range(0, 2) != 0);
            m_wready  = ($urandom_range(0, 2) != 0);
            m_bvalid  = ($urandom_range(0, 2) != 0);
            m_bresp   = ($urandom_range(0, 4) == 0) ? 2'($urandom) : 2'b00;
            m_arready = ($urandom_range(0, 2) != 0);
            m_rvalid  = ($urandom_range(0, 2) != 0);
            m_rdata   = {$urandom, $urandom};
            m_rresp   = ($urandom_range(0, 4) == 0) ? 2'($urandom) : 2'b00;
            tick();
        end
        rst = 1'b0;
        clr_in();
        chk1("random progress", 1'(n_resp > 200), 1'b1);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
